// File: rtl/chroma_upsample_stream.sv
// JPEG chroma upsampler: passes luma through and expands each chroma block into 1, 2 or 4
// nearest-neighbour blocks according to the MCU subsampling mode, one block per beat.
module chroma_upsample_stream #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned N     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [1:0]                          mode,
  input  logic                                valid_in,
  output logic                                ready_in,
  input  logic [1:0]                          ch_in,
  input  logic [N-1:0][N-1:0][WIDTH-1:0]      block_in,
  output logic                                valid_out,
  input  logic                                ready_out,
  output logic [1:0]                          ch_out,
  output logic [1:0]                          sub_idx_out,
  output logic [N-1:0][N-1:0][WIDTH-1:0]      block_out,
  output logic                                seq_err
);

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned Half = N / 2;

  localparam logic [1:0] Md444 = 2'd0;
  localparam logic [1:0] Md422 = 2'd1;
  localparam logic [1:0] Md420 = 2'd2;

  localparam logic [1:0] ChY  = 2'd0;
  localparam logic [1:0] ChCb = 2'd1;
  localparam logic [1:0] ChCr = 2'd2;

  typedef logic [N-1:0][N-1:0][WIDTH-1:0] blk_t;

  typedef enum logic [1:0] {
    StExpY,
    StExpCb,
    StExpCr
  } st_e;

  // Reserved mode 3 behaves as 4:4:4.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? Md444 : m;
  endfunction

  // Index of the last Y block in an MCU, which equals the last chroma sub-block index.
  function automatic logic [1:0] last_idx(input logic [1:0] md);
    logic [1:0] res;
    case (md)
      Md422:   res = 2'd1;
      Md420:   res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  function automatic blk_t expand(input blk_t src, input logic [1:0] md, input logic [1:0] k);
    blk_t           res;
    logic [IW-1:0]  sr;
    logic [IW-1:0]  sc;
    res = src;
    for (int i = 0; i < int'(N); i++) begin
      for (int j = 0; j < int'(N); j++) begin
        case (md)
          Md422: begin
            sr = IW'(i);
            sc = IW'(int'(k[0]) * int'(Half) + j / 2);
          end
          Md420: begin
            sr = IW'(int'(k[1]) * int'(Half) + i / 2);
            sc = IW'(int'(k[0]) * int'(Half) + j / 2);
          end
          default: begin
            sr = IW'(i);
            sc = IW'(j);
          end
        endcase
        res[IW'(i)][IW'(j)] = src[sr][sc];
      end
    end
    return res;
  endfunction

  st_e        st_q;
  logic [1:0] y_cnt_q;
  logic [1:0] md_q;
  blk_t       src_q;
  logic       valid_q;
  logic [1:0] ch_q;
  logic [1:0] sub_q;
  blk_t       blk_q;
  logic       last_q;
  logic       seq_err_q;

  logic       accept;
  logic       fire;
  logic [1:0] exp_ch;
  logic       ch_ok;
  logic [1:0] md_new;
  blk_t       first_beat;
  blk_t       next_beat;

  always_comb begin
    exp_ch = ChY;
    unique case (st_q)
      StExpCb: exp_ch = ChCb;
      StExpCr: exp_ch = ChCr;
      default: exp_ch = ChY;
    endcase
  end

  assign ready_in = !valid_q || (ready_out && last_q);
  assign accept   = valid_in && ready_in;
  assign fire     = valid_q && ready_out;
  assign ch_ok    = (ch_in == exp_ch);

  // Mode is sampled only by the first Y of an MCU.
  assign md_new     = (st_q == StExpY && y_cnt_q == 2'd0) ? norm_mode(mode) : md_q;
  assign first_beat = expand(block_in, md_q, 2'd0);
  assign next_beat  = expand(src_q, md_q, sub_q + 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= StExpY;
      y_cnt_q   <= 2'd0;
      md_q      <= Md444;
      src_q     <= '0;
      valid_q   <= 1'b0;
      ch_q      <= 2'd0;
      sub_q     <= 2'd0;
      blk_q     <= '0;
      last_q    <= 1'b1;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= accept && !ch_ok;
      if (accept && ch_ok) begin
        valid_q <= 1'b1;
        sub_q   <= 2'd0;
        ch_q    <= ch_in;
        unique case (st_q)
          StExpY: begin
            blk_q  <= block_in;
            last_q <= 1'b1;
            md_q   <= md_new;
            if (y_cnt_q == last_idx(md_new)) begin
              st_q <= StExpCb;
            end else begin
              y_cnt_q <= y_cnt_q + 2'd1;
            end
          end
          StExpCb, StExpCr: begin
            src_q  <= block_in;
            blk_q  <= first_beat;
            last_q <= (last_idx(md_q) == 2'd0);
            if (st_q == StExpCb) begin
              st_q <= StExpCr;
            end else begin
              st_q    <= StExpY;
              y_cnt_q <= 2'd0;
            end
          end
          default: st_q <= StExpY;
        endcase
      end else if (fire) begin
        // A dropped block accepted alongside the final beat lands here too.
        if (last_q) begin
          valid_q <= 1'b0;
        end else begin
          sub_q  <= sub_q + 2'd1;
          blk_q  <= next_beat;
          last_q <= ((sub_q + 2'd1) == last_idx(md_q));
        end
      end
    end
  end

  assign valid_out   = valid_q;
  assign ch_out      = ch_q;
  assign sub_idx_out = sub_q;
  assign block_out   = blk_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_chroma_upsample_stream.sv
// Randomised and directed bench for chroma_upsample_stream against a queue-based
// model of the MCU sequence and nearest-neighbour expansion.
module tb_chroma_upsample_stream;

  localparam int unsigned WIDTH = 9;
  localparam int unsigned N     = 8;
  localparam int unsigned BW    = N * N * WIDTH;
  localparam int unsigned IW    = $clog2(N);

  typedef logic [N-1:0][N-1:0][WIDTH-1:0] blk_t;
  typedef struct {
    logic [1:0] ch;
    logic [1:0] sub;
    blk_t       blk;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       valid_in = 1'b0;
  logic       ready_in;
  logic [1:0] ch_in = 2'd0;
  blk_t       block_in = '0;
  logic       valid_out;
  logic       ready_out = 1'b1;
  logic [1:0] ch_out;
  logic [1:0] sub_idx_out;
  blk_t       block_out;
  logic       seq_err;

  chroma_upsample_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .valid_in    (valid_in),
    .ready_in    (ready_in),
    .ch_in       (ch_in),
    .block_in    (block_in),
    .valid_out   (valid_out),
    .ready_out   (ready_out),
    .ch_out      (ch_out),
    .sub_idx_out (sub_idx_out),
    .block_out   (block_out),
    .seq_err     (seq_err)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t q[$];
  int    y_seen   = 0;
  bit    cb_seen  = 0;
  int    mcu_md   = 0;
  bit    err_pend = 0;
  int    beats    = 0;
  int    cb_beats = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ny_of(input int md);
    return (md == 2) ? 4 : (md == 1) ? 2 : 1;
  endfunction

  function automatic logic [1:0] exp_ch();
    if (y_seen < ny_of(mcu_md)) return 2'd0;
    return cb_seen ? 2'd2 : 2'd1;
  endfunction

  task automatic model_reset();
    q.delete();
    y_seen   = 0;
    cb_seen  = 0;
    mcu_md   = 0;
    err_pend = 0;
  endtask

  task automatic model_accept(input logic [1:0] ch, input blk_t b, input logic [1:0] md);
    beat_t e;
    blk_t  o;
    int    hs;
    int    vs;
    if (ch != exp_ch()) begin
      err_pend = 1;
      return;
    end
    if (ch == 2'd0) begin
      if (y_seen == 0) mcu_md = (md == 2'd3) ? 0 : int'(md);
      y_seen++;
      e.ch  = 2'd0;
      e.sub = 2'd0;
      e.blk = b;
      q.push_back(e);
    end else begin
      hs = (mcu_md == 0) ? 1 : 2;
      vs = (mcu_md == 2) ? 2 : 1;
      for (int k = 0; k < hs * vs; k++) begin
        for (int r = 0; r < int'(N); r++) begin
          for (int c = 0; c < int'(N); c++) begin
            o[IW'(r)][IW'(c)] = b[IW'((k / hs) * (int'(N) / vs) + r / vs)]
                                 [IW'((k % hs) * (int'(N) / hs) + c / hs)];
          end
        end
        e.ch  = ch;
        e.sub = 2'(k);
        e.blk = o;
        q.push_back(e);
      end
      if (ch == 2'd1) begin
        cb_seen = 1;
      end else begin
        y_seen  = 0;
        cb_seen = 0;
      end
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(output bit acc);
    beat_t b;
    bit    exp_rdy;
    #1;
    exp_rdy = (q.size() == 0) || (ready_out && q.size() == 1);
    check("ready_in", BW'(ready_in), BW'(exp_rdy));
    check("valid_out", BW'(valid_out), BW'(q.size() != 0));
    check("seq_err", BW'(seq_err), BW'(err_pend));
    err_pend = 0;
    if (valid_out && ready_out && q.size() != 0) begin
      b = q.pop_front();
      check("ch_out", BW'(ch_out), BW'(b.ch));
      check("sub_idx_out", BW'(sub_idx_out), BW'(b.sub));
      check("block_out", BW'(block_out), BW'(b.blk));
      beats++;
      if (ch_out == 2'd1) cb_beats++;
    end
    acc = valid_in && ready_in;
    if (acc) model_accept(ch_in, block_in, mode);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] ch, input blk_t b);
    bit acc;
    int n;
    valid_in = 1'b1;
    ch_in    = ch;
    block_in = b;
    acc      = 0;
    n        = 0;
    while (!acc && n < 40) begin
      step(acc);
      n++;
    end
    check("send_accept", BW'(acc), BW'(1));
    valid_in = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    valid_in  = 1'b0;
    ready_out = 1'b1;
    n         = 0;
    while ((q.size() != 0 || valid_out) && n < 20) begin
      step(acc);
      n++;
    end
    check("drain", BW'(q.size()), BW'(0));
  endtask

  function automatic blk_t pat();
    blk_t b;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) b[IW'(r)][IW'(c)] = WIDTH'(8 * r + c + 1);
    return b;
  endfunction

  function automatic blk_t sgn();
    blk_t b;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) b[IW'(r)][IW'(c)] = 9'h100 + WIDTH'(r);
    return b;
  endfunction

  function automatic blk_t rnd();
    blk_t b;
    for (int r = 0; r < int'(N); r++)
      for (int c = 0; c < int'(N); c++) b[IW'(r)][IW'(c)] = WIDTH'($urandom);
    return b;
  endfunction

  initial begin
    bit   acc;
    int   b0;
    blk_t held;

    // Reset values
    #1;
    check("rst_valid", BW'(valid_out), BW'(0));
    check("rst_ready", BW'(ready_in), BW'(1));
    check("rst_block", BW'(block_out), BW'(0));
    check("rst_ch", BW'(ch_out), BW'(0));
    check("rst_sub", BW'(sub_idx_out), BW'(0));
    check("rst_seq_err", BW'(seq_err), BW'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // 4:2:0 MCU at full throughput
    mode = 2'd2;
    b0   = beats;
    repeat (4) send(2'd0, pat());
    send(2'd1, pat());
    check("k0_00", BW'(block_out[0][0]), BW'(1));
    check("k0_11", BW'(block_out[1][1]), BW'(1));
    check("k0_22", BW'(block_out[2][2]), BW'(10));
    repeat (3) step(acc);
    check("k3_sub", BW'(sub_idx_out), BW'(3));
    check("k3_00", BW'(block_out[0][0]), BW'(37));
    check("k3_77", BW'(block_out[7][7]), BW'(64));
    send(2'd2, pat());
    drain();
    check("mcu420_beats", BW'(beats - b0), BW'(12));

    // 4:2:2
    mode = 2'd1;
    b0   = cb_beats;
    repeat (2) send(2'd0, pat());
    send(2'd1, pat());
    step(acc);
    check("k422_sub", BW'(sub_idx_out), BW'(1));
    check("k422_00", BW'(block_out[0][0]), BW'(5));
    check("k422_01", BW'(block_out[0][1]), BW'(5));
    check("k422_77", BW'(block_out[7][7]), BW'(64));
    send(2'd2, pat());
    drain();
    check("k422_cb_beats", BW'(cb_beats - b0), BW'(2));

    // 4:4:4 with negative samples
    mode = 2'd0;
    for (int ch = 0; ch < 3; ch++) begin
      send(2'(ch), sgn());
      check("s444_00", BW'(block_out[0][0]), BW'(9'h100));
      check("s444_sub", BW'(sub_idx_out), BW'(0));
    end
    drain();

    // Backpressure on beat 1 of a 4:2:0 Cb
    mode = 2'd2;
    repeat (4) send(2'd0, rnd());
    send(2'd1, rnd());
    step(acc);
    held      = block_out;
    ready_out = 1'b0;
    repeat (5) begin
      step(acc);
      check("bp_hold", BW'(block_out), BW'(held));
      check("bp_sub", BW'(sub_idx_out), BW'(1));
      check("bp_ready", BW'(ready_in), BW'(0));
    end
    ready_out = 1'b1;
    step(acc);
    check("bp_sub2", BW'(sub_idx_out), BW'(2));
    step(acc);
    check("bp_sub3", BW'(sub_idx_out), BW'(3));
    send(2'd2, rnd());
    drain();

    // Sequence error: Cb after two Y, mode change mid-MCU ignored
    mode = 2'd2;
    send(2'd0, rnd());
    mode = 2'd0;
    send(2'd0, rnd());
    send(2'd1, rnd());
    check("seq_err_pulse", BW'(seq_err), BW'(1));
    b0 = cb_beats;
    repeat (2) send(2'd0, rnd());
    send(2'd1, rnd());
    drain();
    check("seq_cb_beats", BW'(cb_beats - b0), BW'(4));
    send(2'd2, rnd());
    drain();

    // Asynchronous reset in the middle of a 4:2:0 Cb expansion
    mode = 2'd2;
    repeat (4) send(2'd0, pat());
    send(2'd1, pat());
    repeat (2) step(acc);
    check("pre_rst_sub", BW'(sub_idx_out), BW'(2));
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", BW'(valid_out), BW'(0));
    check("arst_ready", BW'(ready_in), BW'(1));
    check("arst_block", BW'(block_out), BW'(0));
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    mode = 2'd0;
    send(2'd0, sgn());
    send(2'd1, sgn());
    send(2'd2, sgn());
    drain();

    // Randomised traffic
    for (int i = 0; i < 2000; i++) begin
      valid_in  = ($urandom_range(0, 3) != 0);
      ch_in     = ($urandom_range(0, 7) != 0) ? exp_ch() : 2'($urandom_range(0, 3));
      mode      = 2'($urandom_range(0, 3));
      ready_out = ($urandom_range(0, 3) != 0);
      block_in  = rnd();
      step(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/chroma_upsample_stream.md
Name: chroma_upsample_stream

Overview:
Streaming successor to the fixed 4:2:0 supersampler. It sits between IDCT/level-shift and colour conversion in the JPEG decode path. It accepts one 8x8 (parametrised NxN) block per handshake, in MCU order Y..Y, Cb, Cr. It passes luma through and expands each chroma block into 1, 2 or 4 nearest-neighbour-upsampled blocks, according to a runtime subsampling mode (4:4:4, 4:2:2, 4:2:0). Output is one block per beat with ready/valid backpressure, plus MCU sequence checking.

Parameters:
WIDTH, 9, signed sample width.
N, 8, block dimension. Must be even and at least 2.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous active-high
mode  in  2  0=4:4:4, 1=4:2:2, 2=4:2:0, 3=reserved (treated as 4:4:4)
valid_in  in  1  upstream block valid
ready_in  out  1  block accepted when valid_in && ready_in
ch_in  in  2  0=Y, 1=Cb, 2=Cr
block_in  in  N*N*WIDTH  signed, indexed [r][c], r=0 top row, c=0 left column
valid_out  out  1  output block valid
ready_out  in  1  downstream ready; beat completes when valid_out && ready_out
ch_out  out  2  channel of output block
sub_idx_out  out  2  sub-block index within an expanded chroma block (0 for Y and 4:4:4)
block_out  out  N*N*WIDTH  signed output block
seq_err  out  1  one-cycle pulse: block with an unexpected channel was dropped

Behaviour:
- Reset (async, immediate):
  - valid_out=0, ready_in=1, ch_out=0, sub_idx_out=0, block_out all 0, seq_err=0.
  - FSM to EXP_Y with y_cnt=0; chroma holding register cleared.
  - Any partial expansion or MCU is discarded.
- Mode decode:
  - Ny (Y blocks per MCU) and K (output blocks per chroma block): 4:4:4 -> 1,1; 4:2:2 -> 2,2; 4:2:0 -> 4,4.
  - mode is latched on acceptance of the first Y of an MCU (y_cnt=0). Changes mid-MCU are ignored until the next MCU.
- Sequence FSM (expected channel):
  - EXP_Y: on an accepted Y, y_cnt++. When y_cnt reaches Ny-1 and that Y is accepted, go to EXP_CB.
  - EXP_CB: on an accepted Cb, go to EXP_CR.
  - EXP_CR: on an accepted Cr, go to EXP_Y with y_cnt=0.
  - Accepted block with ch_in != expected, or ch_in=3: block dropped, seq_err=1 for the cycle after acceptance, FSM unchanged, no output.
- Datapath, latency 1. An accepted block appears on block_out on the next cycle with valid_out=1.
  - Y (or any chroma in 4:4:4): block_out = block_in, sub_idx_out=0, one beat.
  - 4:2:2 chroma, beat k in {0,1}: out[i][j] = in[i][k*N/2 + j/2].
  - 4:2:0 chroma, beat k in {0..3}, qr = k>>1, qc = k&1: out[i][j] = in[qr*N/2 + i/2][qc*N/2 + j/2].
  - Chroma beats are issued in order k=0..K-1 from the registered source block. Each subsequent beat is presented the cycle after the previous beat completes.
  - Pure copy: no arithmetic, no width change; sign preserved bit-exact.
- Handshake:
  - ready_in = !valid_out || (ready_out && last_beat), where last_beat means sub_idx_out == K_latched-1. ready_in is combinational from ready_out.
  - While valid_out && !ready_out, block_out, ch_out and sub_idx_out are held stable.
  - Back-to-back accept-and-complete on the same cycle sustains one block per cycle with no bubble.
  - During chroma expansion, ready_in=0 until the final beat completes.
  - If valid_out=0 and nothing is accepted, outputs keep their last values with valid_out=0.
- Dropped blocks (seq_err) do not affect valid_out; an in-flight output beat continues normally.

Test Plan:
- Reset: assert rst mid-cycle during a 4:2:0 Cb expansion (sub_idx_out=2) -> immediately valid_out=0, ready_in=1, block_out=0. Next Y is accepted as the MCU start.
- 4:2:0 MCU with ready_out=1: four Y blocks with in[r][c]=8r+c+1, then Cb, then Cr, same data -> Y passes through one per cycle; Cb emits 4 beats with ready_in=0 for 3 cycles.
  - k=0: out[0][0]=1, out[1][1]=1, out[2][2]=10.
  - k=3: out[0][0]=37, out[7][7]=64.
  - Cr identical; total 12 output beats.
- 4:2:2: mode=1, two Y then Cb with in[r][c]=8r+c+1 -> Cb beat 1: out[0][0]=5, out[0][1]=5, out[7][7]=64; exactly 2 chroma beats per channel.
- 4:4:4 and sign: mode=0, Y, Cb, Cr with in[r][c] = -256 + r -> each passes unchanged in one beat, sub_idx_out=0, value -256 preserved.
- Backpressure: hold ready_out=0 for 5 cycles during 4:2:0 Cb beat 1 -> outputs stable, ready_in=0. After release, beats 2 and 3 follow on consecutive cycles.
- Sequence error: in 4:2:0, send Cb after only 2 Y -> seq_err pulses once, no output beat for it. Two further Y then Cb are accepted normally. Changing mode to 0 after the first Y has no effect on that MCU.
